// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment patterns, slot index type and blanking helper
package seg7_pkg;

   localparam int SLOT_IDX_W = 2;
   typedef logic [SLOT_IDX_W-1:0] slot_idx_t;

   // Active-high gfedcba patterns
   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   // One frame's worth of display state, captured when slot 0 begins
   typedef struct packed {
      logic [3:0][3:0] dig;
      logic [3:0]      dp;
      logic            blank_lz_en;
   } snapshot_t;

   // True when the digit in slot idx is a leading zero; invalid codes count as nonzero
   function automatic logic lz_blank(input logic [3:0][3:0] dig, input slot_idx_t idx);
      logic res;
      res = 1'b0;
      case (idx)
         2'd3:    res = (dig[3] == 4'd0);
         2'd2:    res = (dig[3] == 4'd0) && (dig[2] == 4'd0);
         2'd1:    res = (dig[3] == 4'd0) && (dig[2] == 4'd0) && (dig[1] == 4'd0);
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - BCD to active-high gfedcba pattern, dash for codes 10-15
module seg7_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Pure lookup; anything outside 0-9 renders as a lone g segment
   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_mux_4d.sv
// rtl/bcd_display_mux_4d.sv - 4-digit time-multiplexed 7-segment driver with frame snapshot
module bcd_display_mux_4d
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV    = 100000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] dig0,
   input  logic [3:0] dig1,
   input  logic [3:0] dig2,
   input  logic [3:0] dig3,
   input  logic [3:0] dp_in,
   input  logic       blank_lz_en,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       scan_tick
);

   localparam int               DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   // Inactive output levels; XOR with these converts internal active-high to pin polarity
   localparam logic [3:0] AN_IDLE  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;
   localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic       DP_IDLE  = SEG_ACTIVE_LOW;

   generate
      if (REFRESH_DIV < 2) begin : g_bad_refresh_div
         $error("bcd_display_mux_4d: REFRESH_DIV must be at least 2");
      end
   endgenerate

   logic [DIV_W-1:0] div_q, div_d;
   slot_idx_t        idx_q, idx_d;
   snapshot_t        snap_q, snap_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             scan_tick_q, scan_tick_d;

   logic             tick;
   logic             capture;
   logic             blank;
   logic [3:0]       cur_digit;
   logic [6:0]       cur_pattern;

   // Divider, slot advance and frame capture; cur_digit/blank describe the slot being entered
   always_comb begin
      tick    = (div_q == DIV_LAST);
      div_d   = tick ? '0 : div_q + 1'b1;
      idx_d   = tick ? idx_q + 1'b1 : idx_q;
      capture = tick && (idx_d == '0);
      snap_d  = snap_q;
      if (capture) begin
         snap_d.dig         = {dig3, dig2, dig1, dig0};
         snap_d.dp          = dp_in;
         snap_d.blank_lz_en = blank_lz_en;
      end
      cur_digit = snap_d.dig[idx_d];
      blank     = snap_d.blank_lz_en && lz_blank(snap_d.dig, idx_d);
   end

   seg7_decoder u_decoder (
      .bcd (cur_digit),
      .seg (cur_pattern)
   );

   // Output image for the next slot, only loaded on the slot-change edge
   always_comb begin
      scan_tick_d = tick;
      an_d        = an_q;
      seg_d       = seg_q;
      dp_d        = dp_q;
      if (tick) begin
         if (blank) begin
            an_d  = AN_IDLE;
            seg_d = SEG_IDLE;
            dp_d  = DP_IDLE;
         end else begin
            an_d  = (4'b0001 << idx_d) ^ AN_IDLE;
            seg_d = cur_pattern ^ SEG_IDLE;
            dp_d  = snap_d.dp[idx_d] ^ DP_IDLE;
         end
      end
   end

   // State and registered outputs; reset parks on slot 3 so the first advance lands on slot 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q       <= '0;
         idx_q       <= 2'd3;
         snap_q      <= '0;
         an_q        <= AN_IDLE;
         seg_q       <= SEG_IDLE;
         dp_q        <= DP_IDLE;
         scan_tick_q <= 1'b0;
      end else begin
         div_q       <= div_d;
         idx_q       <= idx_d;
         snap_q      <= snap_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         scan_tick_q <= scan_tick_d;
      end
   end

   assign an        = an_q;
   assign seg       = seg_q;
   assign dp        = dp_q;
   assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_bcd_display_mux_4d.sv
// tb/tb_bcd_display_mux_4d.sv - scoreboard bench for bcd_display_mux_4d with random frames
module tb_bcd_display_mux_4d;

   localparam int RD = 4;
   localparam int ND = 5;
   localparam int NF = 25;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] dig0, dig1, dig2, dig3, dp_in;
   logic       blank_lz_en;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic       scan_tick;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;

   logic [15:0] fr_dig[NF];
   logic [3:0]  fr_dp[NF];
   logic        fr_lz[NF];
   int          fr_k[NF];

   bcd_display_mux_4d #(
      .REFRESH_DIV    (RD),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (rst),
      .dig0        (dig0),
      .dig1        (dig1),
      .dig2        (dig2),
      .dig3        (dig3),
      .dp_in       (dp_in),
      .blank_lz_en (blank_lz_en),
      .seg         (seg),
      .dp          (dp),
      .an          (an),
      .scan_tick   (scan_tick)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Pin-level (active-low) character shapes as drawn on the display
   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   function automatic logic [3:0] anode(input int slot);
      case (slot)
         0:       return 4'b1110;
         1:       return 4'b1101;
         2:       return 4'b1011;
         default: return 4'b0111;
      endcase
   endfunction

   // Slots above the most significant nonzero digit go dark when blanking is on
   function automatic exp_t model(input logic [15:0] digs, input logic [3:0] dpv,
                                  input logic lz, input int slot);
      exp_t e;
      int   msd;
      msd = 0;
      for (int i = 3; i >= 1; i--)
         if (msd == 0 && digs[i*4 +: 4] != 4'd0) msd = i;
      if (lz && slot > msd) begin
         e.an  = 4'b1111;
         e.seg = 7'b1111111;
         e.dp  = 1'b1;
      end else begin
         e.an  = anode(slot);
         e.seg = glyph(digs[slot*4 +: 4]);
         e.dp  = ~dpv[slot];
      end
      return e;
   endfunction

   task automatic push_frame(input int f);
      for (int s = 0; s < 4; s++) exp_q.push_back(model(fr_dig[f], fr_dp[f], fr_lz[f], s));
   endtask

   task automatic apply(input int f);
      {dig3, dig2, dig1, dig0} = fr_dig[f];
      dp_in                    = fr_dp[f];
      blank_lz_en              = fr_lz[f];
   endtask

   // Monitor: pops one expectation per slot change, checks hold and spacing in between
   int         cyc = 0;
   logic [3:0] last_an  = 4'hF;
   logic [6:0] last_seg = 7'h7F;
   logic       last_dp  = 1'b1;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         cyc      = 0;
         last_an  = 4'hF;
         last_seg = 7'h7F;
         last_dp  = 1'b1;
      end else begin
         cyc++;
         chk("an_at_most_one", 32'($countones(~an) <= 1), 32'd1);
         if (scan_tick) begin
            chk("tick_spacing", cyc, RD);
            cyc = 0;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard_empty: slot change with no expectation at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("slot_an", an, e.an);
               chk("slot_seg", seg, e.seg);
               chk("slot_dp", dp, e.dp);
            end
            last_an  = an;
            last_seg = seg;
            last_dp  = dp;
         end else begin
            chk("hold_an", an, last_an);
            chk("hold_seg", seg, last_seg);
            chk("hold_dp", dp, last_dp);
            if (cyc > 2 * RD) begin
               checks++;
               errors++;
               $display("FAIL tick_timeout: no scan_tick for %0d cycles", cyc);
               cyc = 0;
            end
         end
      end
   end

   initial begin
      fr_dig[0] = 16'h1234; fr_dp[0] = 4'b0000; fr_lz[0] = 1'b0; fr_k[0] = 9;
      fr_dig[1] = 16'h5678; fr_dp[1] = 4'b0000; fr_lz[1] = 1'b0; fr_k[1] = 5;
      fr_dig[2] = 16'h0007; fr_dp[2] = 4'b0000; fr_lz[2] = 1'b1; fr_k[2] = 3;
      fr_dig[3] = 16'h0000; fr_dp[3] = 4'b0000; fr_lz[3] = 1'b1; fr_k[3] = 12;
      fr_dig[4] = 16'h00C0; fr_dp[4] = 4'b0010; fr_lz[4] = 1'b1; fr_k[4] = 7;
      for (int f = ND; f < NF; f++) begin
         for (int d = 0; d < 4; d++)
            fr_dig[f][d*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         fr_dp[f] = 4'($urandom_range(0, 15));
         fr_lz[f] = 1'($urandom_range(0, 1));
         fr_k[f]  = $urandom_range(1, 15);
      end

      rst = 1'b1;
      apply(0);
      repeat (3) begin
         @(negedge clk);
         chk("reset_an", an, 4'hF);
         chk("reset_seg", seg, 7'h7F);
         chk("reset_dp", dp, 1'b1);
         chk("reset_tick", scan_tick, 1'b0);
      end
      push_frame(0);
      #1 rst = 1'b0;

      // Frame f is captured here; the next frame's inputs arrive k clocks into it
      repeat (RD) @(posedge clk);
      for (int f = 0; f < NF - 1; f++) begin
         repeat (fr_k[f]) @(posedge clk);
         #1;
         apply(f + 1);
         push_frame(f + 1);
         repeat (4 * RD - fr_k[f]) @(posedge clk);
      end

      // Asynchronous reset in the middle of slot 2
      repeat (2 * RD + 1) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_reset_an", an, 4'hF);
      chk("async_reset_seg", seg, 7'h7F);
      chk("async_reset_dp", dp, 1'b1);
      chk("async_reset_tick", scan_tick, 1'b0);
      exp_q.delete();
      push_frame(NF - 1);
      push_frame(NF - 1);
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (9 * RD - 1) @(posedge clk);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_display_mux_4d.md
Name: bcd_display_mux_4d

Overview:
Downstream consumer of the 4-digit BCD counter (digits 0–9999). Time-multiplexes four BCD digits onto one common-anode 7-segment display: one digit slot every REFRESH_DIV clocks, cycling 0→1→2→3.
- Captures all four digits once per frame so a changing counter never tears across a frame.
- Supports leading-zero blanking and per-digit decimal points.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz); must be >=2, checked at elaboration
SEG_ACTIVE_LOW, 1, 1 = seg/dp outputs active-low
AN_ACTIVE_LOW, 1, 1 = anode outputs active-low

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
dig0  in  4  BCD units
dig1  in  4  BCD tens
dig2  in  4  BCD hundreds
dig3  in  4  BCD thousands
dp_in  in  4  decimal point request, bit i = digit i
blank_lz_en  in  1  leading-zero blanking enable
seg  out  7  segments, seg[6:0] = g,f,e,d,c,b,a
dp  out  1  decimal point
an  out  4  anode select, an[i] = digit i
scan_tick  out  1  one-cycle pulse on every slot change

Behaviour:
- Reset is asynchronous and active-high, and takes effect immediately:
  - divider=0, idx=3, snapshot regs (digits, dp, blank_lz_en)=0.
  - All outputs registered and inactive: an=1111, seg=1111111, dp=1 (defaults shown active-low), scan_tick=0.
- Divider: counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and sets tick.
- On the tick edge:
  - idx advances 3→0, else idx+1.
  - scan_tick=1 for that cycle only.
  - an/seg/dp are registered for the new idx, so outputs change on the same edge as idx.
- Frame capture: when the new idx is 0, dig0..3, dp_in and blank_lz_en are latched into the snapshot. Slot 0's outputs use these newly captured values. Slots 1–3 use the snapshot only; input changes mid-frame have no effect until the next slot 0.
- First displayed slot is digit 0, REFRESH_DIV cycles after reset release. Each slot is held exactly REFRESH_DIV cycles; a full frame is 4*REFRESH_DIV cycles.
- Decode (active-high internal, gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Values 10–15 display dash 40 (g only).
- Leading-zero blanking (snapshot blank_lz_en=1):
  - Digit 3 is blanked if its value is 0.
  - Digit 2 is blanked if digits 3 and 2 are 0.
  - Digit 1 is blanked if digits 3..1 are 0.
  - Digit 0 is never blanked, so 0000 shows "0".
  - Invalid (10–15) counts as nonzero.
- Blanked slot: anode inactive, seg off, dp off. The slot timing is unchanged.
- Non-blanked slot: exactly one anode active, seg = decoded pattern, dp active iff snapshot dp bit set.
- Polarity inversion is applied at the output registers per parameters.
- Never more than one anode active in any cycle.

Decomposition:
- Package seg7_pkg holds:
  - localparams for the ten digit patterns, SEG_DASH=7'h40, SEG_OFF=7'h00.
  - The slot-index width (2).
- Natural sub-module: seg7_decoder, combinational 4-bit BCD → 7-bit active-high pattern with dash for 10–15.
- The top contains the divider, idx FSM, snapshot, blanking logic and output registers.

Test Plan:
Bench uses REFRESH_DIV=4, both polarities active-low.
1. Reset held then released → during reset an=1111, seg=1111111, dp=1, scan_tick=0. 4 clks after release: an=1110, scan_tick pulses once.
2. dig3..0=1,2,3,4, lz off, dp_in=0 → four slots of 4 clks each:
   - an=1110 seg=0011001
   - an=1101 seg=0110000
   - an=1011 seg=0100100
   - an=0111 seg=1111001
   - sequence repeats.
3. Leading-zero blanking, blank_lz_en=1:
   - 0,0,0,7 → slot 0 shows seg=1111000; slots 1–3 show an=1111, seg=1111111.
   - 0,0,0,0 → slot 0 shows seg=1000000.
4. Frame coherence:
   - Change inputs from 1234 to 5678 during slot 2 → slots 2–3 still show 2 and 1.
   - The next slot 0 shows 8 (seg=0000000).
5. Invalid digit and dp:
   - dig1=4'hC, dig3=dig2=0, lz on → slot 1 seg=0111111 (dash, not blanked); slots 2–3 blanked.
   - dp_in=0010 → dp=0 only in slot 1.
6. Reset asserted asynchronously mid-slot 2 → an=1111 and seg=1111111 before the next clk edge. After release, the first visible slot is digit 0, 4 clks later.
